// File: rtl/toplevel_soc_keycode_fifo.sv
// Keycode FIFO with an Avalon-MM register window and held-keycode outputs.
// FIFO head is presented combinationally (key_data/key_valid) and popped by
// key_ready. Registers: PUSH (0), STATUS (1), CONTROL (2), held keycodes (3+n).
module toplevel_soc_keycode_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CHANNELS   = 6
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [3:0]                     address,
   input  logic                           chipselect,
   input  logic                           write_n,
   input  logic                           read,
   input  logic [31:0]                    writedata,
   output logic [31:0]                    readdata,
   output logic [CHANNELS*DATA_WIDTH-1:0] out_port,
   output logic [DATA_WIDTH-1:0]          key_data,
   output logic                           key_valid,
   input  logic                           key_ready,
   output logic                           irq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

   // Storage and FIFO bookkeeping
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
   logic [LVL_W-1:0]      level_reg, level_next;
   logic                  overflow_reg, overflow_next;
   logic                  irq_en_reg, irq_en_next;
   logic                  irq_reg;

   // Decoded bus events
   logic bus_write;
   logic push_req;
   logic ctrl_write;
   logic flush;
   logic overflow_clear;
   logic pop_fire;
   logic push_fire;
   logic push_drop;
   logic empty;
   logic full;
   logic [DATA_WIDTH-1:0] head;
   logic [7:0]            level_byte;

   // The read strobe has no side effects here; readdata is a pure address decode.
   logic unused_ok;
   assign unused_ok = &{1'b0, read, writedata};

   assign bus_write      = chipselect & ~write_n;
   assign push_req       = bus_write && (address == 4'd0);
   assign ctrl_write     = bus_write && (address == 4'd2);
   assign flush          = ctrl_write & writedata[0];
   assign overflow_clear = ctrl_write & writedata[1];

   assign empty     = (level_reg == '0);
   assign full      = (level_reg == FULL_LEVEL);
   assign pop_fire  = key_ready & ~empty;
   // A push into a full FIFO still lands when the head leaves on the same edge.
   assign push_fire = push_req & (~full | pop_fire);
   assign push_drop = push_req & full & ~pop_fire;

   assign head       = mem[rd_ptr_reg];
   assign key_valid  = ~empty;
   assign key_data   = empty ? '0 : head;
   assign level_byte = 8'(level_reg);
   assign irq        = irq_reg;

   // Next-state for pointers, level, overflow and interrupt enable
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      level_next    = level_reg;
      overflow_next = overflow_reg;
      irq_en_next   = irq_en_reg;

      if (flush) begin
         // Flush wins over any push/pop arriving on the same edge
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         level_next  = '0;
      end else begin
         if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
         if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         if (push_fire && !pop_fire)      level_next = level_reg + LVL_W'(1);
         else if (pop_fire && !push_fire) level_next = level_reg - LVL_W'(1);
      end

      // Setting overflow is evaluated last so it beats a same-cycle clear
      if (overflow_clear) overflow_next = 1'b0;
      if (push_drop)      overflow_next = 1'b1;

      if (ctrl_write) irq_en_next = writedata[2];
   end

   // FIFO state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
         irq_en_reg   <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_next;
         overflow_reg <= overflow_next;
         irq_en_reg   <= irq_en_next;
         irq_reg      <= irq_en_reg & (~empty | overflow_reg);
      end
   end

   // Entry storage; contents need no reset because level gates visibility
   always_ff @(posedge clk) begin
      if (push_fire && !flush) mem[wr_ptr_reg] <= writedata[DATA_WIDTH-1:0];
   end

   // One held-keycode register per channel, each driving its out_port slice
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [DATA_WIDTH-1:0] held_reg;

      // Load the held keycode when its register address is written
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            held_reg <= '0;
         end else if (bus_write && (address == 4'(3 + gi))) begin
            held_reg <= writedata[DATA_WIDTH-1:0];
         end
      end

      assign out_port[gi*DATA_WIDTH +: DATA_WIDTH] = held_reg;
   end

   // Zero-latency register read mux; unmapped addresses read zero
   always_comb begin
      readdata = '0;
      case (address)
         4'd0: begin
            if (!empty) readdata = 32'(head);
         end
         4'd1: readdata = {16'd0, level_byte, 5'd0, overflow_reg, full, empty};
         4'd2: readdata = {29'd0, irq_en_reg, 2'b00};
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (address == 4'(3 + i)) readdata = 32'(out_port[i*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_toplevel_soc_keycode_fifo.sv
// Self-checking bench for toplevel_soc_keycode_fifo: directed scenarios plus
// randomized traffic, all checked against a queue-based reference model.
`timescale 1ns/100ps
module tb_toplevel_soc_keycode_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CH    = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic          read = 1'b0;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [CH*DW-1:0] out_port;
   logic [DW-1:0] key_data;
   logic          key_valid;
   logic          key_ready = 1'b0;
   logic          irq;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   bit            ovf_m;
   bit            irq_en_m;
   bit            irq_m;
   logic [DW-1:0] held_m [CH];

   toplevel_soc_keycode_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNELS(CH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .read      (read),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port),
      .key_data  (key_data),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .irq       (irq)
   );

   always #10 clk = ~clk;

   task automatic model_reset();
      q.delete();
      ovf_m    = 0;
      irq_en_m = 0;
      irq_m    = 0;
      foreach (held_m[i]) held_m[i] = '0;
   endtask

   function automatic logic [31:0] exp_status();
      int lvl;
      lvl = q.size();
      return 32'((lvl << 8) | (int'(ovf_m) << 2) | (int'(lvl == DEPTH) << 1) | int'(lvl == 0));
   endfunction

   function automatic logic [CH*DW-1:0] exp_out_port();
      logic [CH*DW-1:0] v;
      v = '0;
      for (int i = 0; i < CH; i++) v[i*DW +: DW] = held_m[i];
      return v;
   endfunction

   // Advance one clock: update the model from the current inputs, then
   // return 1ns after the edge with outputs settled.
   task automatic step();
      bit wr, ctl, pop, irq_next, set_ovf;
      int a;
      wr       = chipselect && !write_n;
      ctl      = wr && (address == 4'd2);
      a        = int'(address);
      irq_next = irq_en_m && (q.size() != 0 || ovf_m);
      pop      = key_ready && (q.size() != 0);
      set_ovf  = 0;
      if (ctl && writedata[0]) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (wr && a == 0) begin
            if (q.size() < DEPTH) q.push_back(writedata[DW-1:0]);
            else set_ovf = 1;
         end
      end
      if (ctl && writedata[1]) ovf_m = 0;
      if (set_ovf) ovf_m = 1;
      if (ctl) irq_en_m = writedata[2];
      if (wr && a >= 3 && a < 3 + CH) held_m[a-3] = writedata[DW-1:0];
      @(posedge clk);
      #1;
      irq_m = irq_next;
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input bit pop = 0);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      key_ready  = pop;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
      key_ready  = 1'b0;
   endtask

   task automatic pop_cycle();
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
   endtask

   task automatic peek(input logic [3:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
      read       = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      total++; if (out_port !== '0) begin bad++; $display("FAIL reset_out_port got=%h want=0", out_port); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
      peek(4'd0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_push_read got=%h want=0", d); end
      peek(4'd1, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_status got=%h want=00000001", d); end
      $display("test_reset: done");
   endtask

   task automatic test_order();
      logic [31:0] d;
      logic [DW-1:0] vals [3];
      vals[0] = 8'h1A; vals[1] = 8'h2B; vals[2] = 8'h3C;
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL order_pre_valid got=%b want=0", key_valid); end
      bus_wr(4'd0, 32'h1A);
      total++; if (key_valid !== 1'b1) begin bad++; $display("FAIL order_valid_after_push got=%b want=1", key_valid); end
      bus_wr(4'd0, 32'h2B);
      bus_wr(4'd0, 32'h3C);
      peek(4'd1, d);
      total++; if (d !== 32'h0300) begin bad++; $display("FAIL order_status got=%h want=00000300", d); end
      for (int i = 0; i < 3; i++) begin
         total++; if (key_data !== vals[i]) begin bad++; $display("FAIL order_pop%0d got=%h want=%h", i, key_data, vals[i]); end
         $display("pop %0d key_data=%h", i, key_data);
         pop_cycle();
      end
      peek(4'd1, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL order_empty got=%h want=00000001", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      logic [DW-1:0] vals [17];
      for (int i = 0; i < 17; i++) begin
         vals[i] = DW'($urandom_range(0, 255));
         bus_wr(4'd0, 32'(vals[i]));
      end
      peek(4'd1, d);
      total++; if (d !== 32'h1006) begin bad++; $display("FAIL ovf_status got=%h want=00001006", d); end
      total++; if (d !== exp_status()) begin bad++; $display("FAIL ovf_status_model got=%h want=%h", d, exp_status()); end
      bus_wr(4'd2, 32'h2);
      peek(4'd1, d);
      total++; if (d !== 32'h1002) begin bad++; $display("FAIL ovf_clear got=%h want=00001002", d); end
      for (int i = 0; i < 16; i++) begin
         total++; if (key_data !== vals[i]) begin bad++; $display("FAIL ovf_drain%0d got=%h want=%h", i, key_data, vals[i]); end
         pop_cycle();
      end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ovf_17th_lost got=%b want=0", key_valid); end
      $display("test_overflow: drained 16 entries");
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      logic [DW-1:0] vals [16];
      for (int i = 0; i < 16; i++) begin
         vals[i] = DW'($urandom_range(0, 255));
         bus_wr(4'd0, 32'(vals[i]));
      end
      bus_wr(4'd0, 32'h55, 1);
      peek(4'd1, d);
      total++; if (d !== 32'h1002) begin bad++; $display("FAIL fullpp_status got=%h want=00001002", d); end
      for (int i = 0; i < 16; i++) begin
         logic [DW-1:0] want;
         want = (i == 15) ? 8'h55 : vals[i+1];
         total++; if (key_data !== want) begin bad++; $display("FAIL fullpp_drain%0d got=%h want=%h", i, key_data, want); end
         pop_cycle();
      end
      $display("test_full_push_pop: done");
   endtask

   task automatic test_held();
      logic [31:0] d;
      bus_wr(4'd3, 32'h04);
      bus_wr(4'd5, 32'h1D);
      total++; if (out_port !== 48'h00_00_00_1D_00_04) begin bad++; $display("FAIL held_out_port got=%h want=00000000001d0004", out_port); end
      bus_wr(4'd15, 32'hFF);
      total++; if (out_port !== exp_out_port()) begin bad++; $display("FAIL held_unmapped_write got=%h want=%h", out_port, exp_out_port()); end
      peek(4'd5, d);
      total++; if (d !== 32'h1D) begin bad++; $display("FAIL held_read5 got=%h want=0000001d", d); end
      peek(4'd15, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL held_unmapped_read got=%h want=0", d); end
      $display("test_held: out_port=%h", out_port);
   endtask

   task automatic test_irq();
      logic [31:0] d;
      bus_wr(4'd2, 32'h4);
      peek(4'd2, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL irq_ctrl_read got=%h want=00000004", d); end
      bus_wr(4'd0, 32'h29);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_same_cycle got=%b want=0", irq); end
      step();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", irq); end
      pop_cycle();
      step();
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want=0", irq); end
      for (int i = 0; i < 5; i++) bus_wr(4'd0, 32'($urandom_range(0, 255)));
      bus_wr(4'd2, 32'h1, 1);
      peek(4'd1, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_flush_status got=%h want=00000001", d); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL irq_flush_valid got=%b want=0", key_valid); end
      step();
      total++; if (irq !== irq_m) begin bad++; $display("FAIL irq_after_flush got=%b want=%b", irq, irq_m); end
      $display("test_irq: done");
   endtask

   task automatic test_random();
      logic [31:0] d;
      int op;
      for (int n = 0; n < 400; n++) begin
         if (key_valid && q.size() != 0) begin
            total++; if (key_data !== q[0]) begin bad++; $display("FAIL rand_key_data cyc=%0d got=%h want=%h", n, key_data, q[0]); end
         end
         op = $urandom_range(0, 99);
         key_ready  = ($urandom_range(0, 1) == 1);
         chipselect = 1'b0;
         write_n    = 1'b1;
         if (op < 45) begin
            address = 4'd0; writedata = $urandom; chipselect = 1'b1; write_n = 1'b0;
         end else if (op < 55) begin
            address = 4'd2;
            writedata = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0)};
            chipselect = 1'b1; write_n = 1'b0;
         end else if (op < 65) begin
            address = 4'($urandom_range(3, 15)); writedata = $urandom; chipselect = 1'b1; write_n = 1'b0;
         end
         step();
         chipselect = 1'b0; write_n = 1'b1; key_ready = 1'b0;
         total++; if (key_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", n, key_valid, q.size() != 0); end
         total++; if (irq !== irq_m) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b want=%b", n, irq, irq_m); end
         peek(4'd1, d);
         total++; if (d !== exp_status()) begin bad++; $display("FAIL rand_status cyc=%0d got=%h want=%h", n, d, exp_status()); end
         total++; if (out_port !== exp_out_port()) begin bad++; $display("FAIL rand_out_port cyc=%0d got=%h want=%h", n, out_port, exp_out_port()); end
      end
      $display("test_random: 400 cycles, level=%0d", q.size());
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      bus_wr(4'd2, 32'h1);
      for (int i = 0; i < 17; i++) bus_wr(4'd0, 32'($urandom_range(0, 255)));
      for (int i = 0; i < 12; i++) pop_cycle();
      bus_wr(4'd2, 32'h4);
      bus_wr(4'd4, 32'hAB);
      step();
      peek(4'd1, d);
      total++; if (d !== 32'h0404) begin bad++; $display("FAIL mid_pre_status got=%h want=00000404", d); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_pre_irq got=%b want=1", irq); end
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      total++; if (out_port !== '0) begin bad++; $display("FAIL mid_out_port got=%h want=0", out_port); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_key_valid got=%b want=0", key_valid); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_irq got=%b want=0", irq); end
      peek(4'd0, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_push_read got=%h want=0", d); end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      key_ready = 1'b1;
      step();
      key_ready = 1'b0;
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_no_pop got=%b want=0", key_valid); end
      bus_wr(4'd0, 32'h77);
      peek(4'd1, d);
      total++; if (d !== 32'h0100) begin bad++; $display("FAIL mid_resume_level got=%h want=00000100", d); end
      total++; if (key_data !== 8'h77) begin bad++; $display("FAIL mid_resume_data got=%h want=77", key_data); end
      $display("test_reset_mid: done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_order();
      test_overflow();
      test_full_push_pop();
      test_held();
      test_irq();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/toplevel_soc_keycode_fifo.md
TOPLEVEL_SOC_KEYCODE_FIFO -- requirements
Module: toplevel_soc_keycode_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set keycode width; legal range 1..16.
REQ-002 Parameter DEPTH, default 16, SHALL set FIFO entries; legal values are powers of two, 2..128.
REQ-003 Parameter CHANNELS, default 6, SHALL set the number of held-keycode registers; legal range 1..12.
REQ-004 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 address  in  4  SHALL select the Avalon-MM register.
REQ-007 chipselect  in  1  SHALL qualify the Avalon-MM access.
REQ-008 write_n  in  1  SHALL be the active-low write strobe.
REQ-009 read  in  1  SHALL be the read strobe; only its side effects depend on it.
REQ-010 writedata  in  32  SHALL be the write data.
REQ-011 readdata  out  32  SHALL be the combinational read data, zero-extended, zero latency.
REQ-012 out_port  out  CHANNELS*DATA_WIDTH  SHALL concatenate the held keycodes, channel 0 in the LSBs.
REQ-013 key_data  out  DATA_WIDTH  SHALL be the FIFO head keycode.
REQ-014 key_valid  out  1  SHALL be high while the FIFO is non-empty.
REQ-015 key_ready  in  1  SHALL pop the head when key_valid and key_ready are both high at a clock edge.
REQ-016 irq  out  1  SHALL be irq_en AND (key_valid OR overflow), registered.

Function
REQ-017 A write is chipselect and not write_n; a read is chipselect and read.
REQ-018 Address 0 (PUSH) SHALL enqueue writedata[DATA_WIDTH-1:0] on write and read as the head keycode, or 0 if empty.
REQ-019 Address 1 (STATUS, read-only) SHALL read as: bit0 empty, bit1 full, bit2 overflow, bits[15:8] level.
REQ-020 Address 2 (CONTROL) SHALL read as: bit2 irq_en, other bits 0.
REQ-021 A CONTROL write with bit0=1 SHALL flush the FIFO; bit0 is self-clearing.
REQ-022 A CONTROL write with bit1=1 SHALL clear overflow (write-1-to-clear).
REQ-023 A CONTROL write SHALL load irq_en from bit2.
REQ-024 Address 3+n, n<CHANNELS, SHALL read/write held keycode n; each written value drives out_port slice n.
REQ-025 Unmapped addresses SHALL read 0 and ignore writes.
REQ-026 level SHALL be $clog2(DEPTH)+1 bits wide, range 0..DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-027 The FIFO SHALL NOT fall through: a push into an empty FIFO raises key_valid on the following cycle.
REQ-028 A push when full with no pop SHALL be dropped, leave contents unchanged and set overflow.
REQ-029 A push and a pop on the same edge SHALL both complete with level unchanged, including when full.
REQ-030 A pop when empty SHALL be ignored and SHALL NOT corrupt the pointers.
REQ-031 Flush SHALL take priority over a same-cycle push and pop: level becomes 0 and both are discarded.
REQ-032 An overflow set SHALL take priority over a same-cycle overflow clear.
REQ-033 key_data SHALL remain stable while key_valid is high and key_ready is low.

Reset
REQ-034 When reset_n is low, the following SHALL be cleared: pointers, level, overflow, irq_en and every held keycode, giving out_port=0, key_valid=0, irq=0 and readdata=0 for PUSH.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents with no further pops.
REQ-036 Operation SHALL resume on the first clock edge after reset_n deasserts.

Verification
REQ-037 Push 0x1A, 0x2B, 0x3C with key_ready=0 -> STATUS level=3, key_data=0x1A; pulse key_ready 3 cycles -> 0x1A, 0x2B, 0x3C in order, then empty=1.
REQ-038 Push 17 values into DEPTH=16 -> full=1, overflow=1, the 17th value is lost; CONTROL write 0x2 -> overflow=0.
REQ-039 With the FIFO full, push 0x55 and pop on the same edge -> level stays 16, 0x55 is the last entry read out.
REQ-040 Write 0x04 to address 3 and 0x1D to address 5 -> out_port[7:0]=0x04, out_port[23:16]=0x1D, other slices 0.
REQ-041 CONTROL=0x4, push 0x29 -> irq=1 one cycle later; pop -> irq=0; flush with 5 entries -> level=0, key_valid=0.
REQ-042 Assert reset_n low with 4 entries and overflow set -> all outputs 0; after release, the first push yields level=1.
